// File: rtl/bin_bcd.sv
// bin_bcd: sequential binary-to-BCD converter (shift-and-add-3, one bit per
// clock) for the calculator datapath.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   conversion request, sampled only while idle
//   num_bin   in   [N_BITS-1:0] unsigned operand, captured on the accepted start
//   busy      out  high while a conversion is running
//   done      out  one-cycle pulse when num_BCD/overflow update
//   num_BCD   out  [4*N_DIGITS-1:0] packed BCD, units digit in [3:0]
//   overflow  out  operand exceeded 10^N_DIGITS-1; held until the next done
//
// A conversion accepted on edge E0 shifts on E1..E(N_BITS) and presents the
// result with done after E(N_BITS). The done cycle is an idle cycle, so a
// start held high restarts immediately: one result per N_BITS+1 clocks.

// Per-digit add-3 correction. Applied to every digit in parallel before the
// shift so that a digit >= 5 carries correctly into the next digit once doubled.
module bin_bcd_dig (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bin_bcd #(
  parameter int N_BITS   = 14,
  parameter int N_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_BITS-1:0]       num_bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*N_DIGITS-1:0]   num_BCD,
  output logic                    overflow
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(N_BITS + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Largest value representable in N_DIGITS decimal digits.
  localparam longint unsigned MAX_VAL = pow10(N_DIGITS) - 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic [N_BITS-1:0]           binreg;
  logic [N_DIGITS-1:0][3:0]    scr;
  logic [N_DIGITS-1:0][3:0]    scr_adj;
  logic [BCD_W-1:0]            adj_flat;
  logic [BCD_W-1:0]            scr_next;
  logic                        ovf_pending;
  logic                        ovf_in;

  // Correction stage, one instance per decimal digit.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
    bin_bcd_dig u_dig (
      .din  (scr[g]),
      .dout (scr_adj[g])
    );
  end

  // Corrected scratch shifted left one place, binreg MSB entering the LSB.
  assign adj_flat = scr_adj;
  assign scr_next = {adj_flat[BCD_W-2:0], binreg[N_BITS-1]};

  assign ovf_in = (64'(num_bin) > MAX_VAL);
  assign busy   = (state == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      binreg      <= '0;
      scr         <= '0;
      ovf_pending <= 1'b0;
      done        <= 1'b0;
      num_BCD     <= '0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= SHIFT;
            binreg      <= num_bin;
            scr         <= '0;
            cnt         <= CNT_W'(N_BITS);
            ovf_pending <= ovf_in;
          end
        end
        SHIFT: begin
          scr    <= scr_next;
          binreg <= {binreg[N_BITS-2:0], 1'b0};
          cnt    <= cnt - 1'b1;
          // Last shift: publish the result directly from the shifted value.
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
            if (ovf_pending) begin
              num_BCD  <= {N_DIGITS{4'h9}};
              overflow <= 1'b1;
            end else begin
              num_BCD  <= scr_next;
              overflow <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_bcd.sv
module tb_bin_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [13:0] num_bin = '0;
  logic        busy;
  logic        done;
  logic [15:0] num_BCD;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  bin_bcd #(.N_BITS(14), .N_DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_bin  (num_bin),
    .busy     (busy),
    .done     (done),
    .num_BCD  (num_BCD),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference via division, independent of shift-and-add.
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // One full conversion: latency, busy profile, result and one-cycle done.
  task automatic conv(input string tag, input logic [13:0] v,
                      input logic [15:0] eb, input logic eo);
    int n;
    int bad_busy;
    n = 0;
    bad_busy = 0;
    @(negedge clk); start = 1'b1; num_bin = v;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (busy !== 1'b1) bad_busy++;
    end
    check({tag, "_latency"}, n, 14);
    check({tag, "_busy_run"}, bad_busy, 0);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_bcd"}, num_BCD, eb);
    check({tag, "_ovf"}, overflow, eo);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done, 0);
    check({tag, "_bcd_held"}, num_BCD, eb);
  endtask

  initial begin
    int n;
    int dones;

    // Asynchronous reset assertion, visible without a clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_bcd", num_BCD, 16'h0000);
    check("rst_ovf", overflow, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    conv("zero", 14'd0, 16'h0000, 1'b0);
    conv("v1234", 14'h04D2, 16'h1234, 1'b0);
    conv("v9999", 14'h270F, 16'h9999, 1'b0);
    conv("v16383", 14'h3FFF, 16'h9999, 1'b1);
    conv("v5", 14'd5, 16'h0005, 1'b0);

    // Start during busy and operand change after capture are both ignored.
    @(negedge clk); start = 1'b1; num_bin = 14'd807;
    @(negedge clk); start = 1'b0;      // after E0
    dones = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 2) num_bin = 14'd999;   // changes before clock 3
      if (c == 4) begin start = 1'b1; num_bin = 14'd42; end
      if (c == 5) start = 1'b0;
      if (done) begin
        dones++;
        check("busy_start_bcd", num_BCD, 16'h0807);
        check("busy_start_ovf", overflow, 0);
      end
    end
    check("busy_start_dones", dones, 1);

    // Reset mid-conversion aborts without a done pulse.
    @(negedge clk); start = 1'b1; num_bin = 14'd555;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 6; c++) @(negedge clk);
    check("pre_abort_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_bcd", num_BCD, 16'h0000);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_bcd_held", num_BCD, 16'h0000);
    conv("v60", 14'd60, 16'h0060, 1'b0);

    // Start held high: back-to-back conversions of 0..20.
    @(negedge clk); start = 1'b1; num_bin = 14'd0;
    for (int k = 0; k <= 20; k++) begin
      n = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        n++;
        if (done) break;
      end
      check($sformatf("stream%0d_interval", k), n, 15);
      check($sformatf("stream%0d_bcd", k), num_BCD, to_bcd(k));
      if (k == 20) start = 1'b0;
      else num_bin = 14'(k + 1);
    end
    for (int c = 0; c < 3; c++) @(negedge clk);
    check("stream_stopped_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
